// File: rtl/dmem_responder_pkg.sv
// Shared pipeline/data-memory definitions: widths, responder FSM encoding,
// wait-state limits and access-counter helpers.
package dmem_responder_pkg;

    // Pipeline datapath constants
    localparam int XLEN          = 32;
    localparam int BYTE_OFFSET_W = 2;

    // Data-memory responder FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

    // Wait-state limits; the down-counter is sized for the maximum
    localparam int WAIT_CYCLES_MIN = 1;
    localparam int WAIT_CYCLES_MAX = 15;
    localparam int WAIT_CNT_W      = 4;

    // Completed-access counters
    localparam int                    ACC_CNT_W   = 16;
    localparam logic [ACC_CNT_W-1:0]  ACC_CNT_MAX = '1;

    // Saturating increment for the access counters
    function automatic logic [ACC_CNT_W-1:0] sat_inc(input logic [ACC_CNT_W-1:0] v);
        return (v == ACC_CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// Word-organised data RAM: single port, synchronous write, asynchronous read.
import dmem_responder_pkg::*;

module dmem_ram #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       rdata
);

    logic [XLEN-1:0] mem [2**ADDR_WIDTH];

    // Write port; contents are deliberately untouched by reset
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline MEM stage: validates requests,
// inserts WAIT_CYCLES wait states, performs the access, counts completions.
import dmem_responder_pkg::*;

module dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_ren,
    input  logic                 mem_wen,
    input  logic [XLEN-1:0]      mem_addr,
    input  logic [XLEN-1:0]      mem_dout,
    output logic [XLEN-1:0]      mem_din,
    output logic                 mem_stall,
    output logic                 mem_err,
    output logic [ACC_CNT_W-1:0] rd_count,
    output logic [ACC_CNT_W-1:0] wr_count
);

    localparam logic [WAIT_CNT_W-1:0] CNT_INIT = WAIT_CNT_W'(WAIT_CYCLES - 1);

    dmem_state_t           state;
    logic [WAIT_CNT_W-1:0] cnt;

    // Request captured at acceptance; inputs are ignored afterwards
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [XLEN-1:0]       acc_wdata;
    logic                  acc_write;

    // Last rejected request, so a held bad request reports only once
    logic                  err_seen;
    logic [XLEN-1:0]       err_addr;

    logic req_any, req_one, aligned, in_range, req_valid, access_now;
    logic [XLEN-1:0] ram_rdata;

    assign req_any    = mem_ren | mem_wen;
    assign req_one    = mem_ren ^ mem_wen;
    assign aligned    = (mem_addr[BYTE_OFFSET_W-1:0] == '0);
    assign in_range   = (mem_addr[XLEN-1:ADDR_WIDTH+BYTE_OFFSET_W] == '0);
    assign req_valid  = req_one & aligned & in_range;
    assign access_now = (state == ST_WAIT) && (cnt == '0);

    // Stall raises in the acceptance cycle itself so the pipeline freezes
    // before the request can advance; reset drops it immediately.
    assign mem_stall = rst & ((state == ST_WAIT) | ((state == ST_IDLE) & req_valid));

    dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .we    (access_now & acc_write),
        .addr  (acc_idx),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    // Responder FSM with request latch, read-data register, counters and error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc_idx   <= '0;
            acc_wdata <= '0;
            acc_write <= 1'b0;
            mem_din   <= '0;
            mem_err   <= 1'b0;
            rd_count  <= '0;
            wr_count  <= '0;
            err_seen  <= 1'b0;
            err_addr  <= '0;
        end else begin
            mem_err <= 1'b0;
            if (!req_any) err_seen <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        state     <= ST_WAIT;
                        cnt       <= CNT_INIT;
                        acc_idx   <= mem_addr[ADDR_WIDTH+BYTE_OFFSET_W-1:BYTE_OFFSET_W];
                        acc_wdata <= mem_dout;
                        acc_write <= mem_wen;
                    end else if (req_any) begin
                        if (!err_seen || (mem_addr != err_addr)) mem_err <= 1'b1;
                        err_seen <= 1'b1;
                        err_addr <= mem_addr;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_DONE;
                        if (acc_write) begin
                            wr_count <= sat_inc(wr_count);
                        end else begin
                            mem_din  <= ram_rdata;
                            rd_count <= sat_inc(rd_count);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                // The request still on the bus here is the one just completed
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
